s_cell_array: RTL

- Parametrised, runtime-programmable array of sequential logic cells.
- Each channel forms a select from paired A/B inputs with AND/OR gating, looks up a 2^SEL_BITS-entry truth table, and drives its output either combinationally or through a flop.
- Truth tables and modes are loaded serially through a handshaked config port into a shadow store. They are committed atomically, so live outputs never see a partial configuration.

---
 rtl/s_cell_array.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/s_cell_array.sv
`default_nettype none
// ============================================================================
//  Module   : s_cell_array
//  Purpose  : Runtime-programmable array of lookup-table logic cells. Each
//             channel gates paired A/B operands into a select, indexes its
//             truth table and drives its output either combinationally or
//             from a per-channel enable flop. Tables and modes are shifted in
//             serially into a shadow store and committed to the live store
//             in a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module s_cell_array #(
  parameter int CH       = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                   CLK,
  input  logic                   CLR_N,
  input  logic                   EN,
  input  logic [CH*SEL_BITS-1:0] A,
  input  logic [CH*SEL_BITS-1:0] B,
  output logic [CH-1:0]          out,
  input  logic                   cfg_start,
  input  logic                   cfg_bit,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic                   cfg_done,
  output logic                   busy
);

  // Per-channel frame: 2^SEL_BITS table bits followed by one mode bit.
  localparam int c_tbl     = 1 << SEL_BITS;
  localparam int c_frame   = c_tbl + 1;
  localparam int c_cfg_len = CH * c_frame;
  localparam int c_cnt_w   = (c_cfg_len > 1) ? $clog2(c_cfg_len) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cfg_len - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cfg_len-1:0]   r_shadow;
  logic [c_cfg_len-1:0]   r_active;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_restart;
  logic                   w_commit;
  logic                   w_ready;
  logic                   w_busy;

  // Configuration FSM state register.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the handshake/control strobes for the load path.
  // A start request always wins over a data bit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_restart   = 1'b0;
    w_commit    = 1'b0;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (cfg_start) begin
          w_restart = 1'b1;
        end else if (cfg_valid) begin
          w_accept = 1'b1;
          if (r_cnt == c_cnt_last) begin
            w_state_nxt = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        w_busy      = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit counter: cleared on (re)start, advances per accepted bit and parks
  // on its terminal value instead of wrapping.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_cnt <= '0;
    end else if (w_restart) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != c_cnt_last)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Shadow store: the accepted bit lands at the position named by the counter.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < c_cfg_len; k++) begin
        if (r_cnt == c_cnt_w'(k)) begin
          r_shadow[k] <= cfg_bit;
        end
      end
    end
  end

  // Live store: copied from the shadow in one edge so no partial config is seen.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_active <= '0;
    end else if (w_commit) begin
      r_active <= r_shadow;
    end
  end

  // Commit pulse, registered so it appears in the cycle after COMMIT.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
    end
  end

  assign cfg_ready = w_ready;
  assign busy      = w_busy;
  assign cfg_done  = r_done;

  genvar gc;
  genvar gi;
  generate
    for (gc = 0; gc < CH; gc++) begin : g_ch
      logic [SEL_BITS-1:0] w_sel;
      logic [c_tbl-1:0]    w_tbl;
      logic                w_mode;
      logic                w_lut;
      logic                r_flop;

      // Even select bits AND the operand pair, odd select bits OR it.
      for (gi = 0; gi < SEL_BITS; gi++) begin : g_sel
        if ((gi % 2) == 0) begin : g_even
          assign w_sel[gi] = A[gc*SEL_BITS + gi] & B[gc*SEL_BITS + gi];
        end else begin : g_odd
          assign w_sel[gi] = A[gc*SEL_BITS + gi] | B[gc*SEL_BITS + gi];
        end
      end

      assign w_tbl  = r_active[gc*c_frame +: c_tbl];
      assign w_mode = r_active[gc*c_frame + c_tbl];
      assign w_lut  = w_tbl[w_sel];

      // Channel flop tracks the lookup whenever enabled, independent of mode.
      always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          r_flop <= 1'b0;
        end else if (EN) begin
          r_flop <= w_lut;
        end
      end

      assign out[gc] = w_mode ? r_flop : w_lut;
    end
  endgenerate

endmodule
`default_nettype wire
